// File: rtl/video_src_mux.sv
// video_src_mux
//   Frame-aligned video source selector with an internal test-pattern
//   generator. External streams and the generator are switched only when
//   both the current and the requested source sit outside a frame, so the
//   downstream HDMI path never receives a torn frame. Source index NUM_SRC
//   selects the pattern generator.
//
// Ports
//   clk            pixel/byte clock
//   reset          asynchronous, active-high
//   src_pix        NUM_SRC packed {R,G,B} pixels, stream i at [i*PIX_W +: PIX_W]
//   src_vld        per-stream pixel valid
//   src_in_line    per-stream line-active flag
//   src_in_frame   per-stream frame-active flag
//   sel_req        requested source (values above NUM_SRC mean pattern)
//   pat_mode       pattern select: 0 bars, 1 ramp, 2 checker, 3 solid
//   out_pix        selected pixel (held while out_vld is low)
//   out_vld        selected valid
//   out_in_line    selected line-active flag
//   out_in_frame   selected frame-active flag
//   sel_active     currently committed source
//   switch_pending request differs from committed source, commit not yet done
//   frame_cnt      completed output frames (wraps)
//   debug_pins     {pg_state, switch_pending, out_in_frame, out_in_line,
//                   out_vld, sel_active[1:0]}
module video_src_mux #(
  parameter int NUM_SRC = 2,
  parameter int PIX_W   = 24,
  parameter int HACTIVE = 960,
  parameter int VACTIVE = 1080,
  parameter int HBLANK  = 64,
  parameter int VBLANK  = 16,
  localparam int SW     = $clog2(NUM_SRC + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*PIX_W-1:0] src_pix,
  input  logic [NUM_SRC-1:0]       src_vld,
  input  logic [NUM_SRC-1:0]       src_in_line,
  input  logic [NUM_SRC-1:0]       src_in_frame,
  input  logic [SW-1:0]            sel_req,
  input  logic [1:0]               pat_mode,
  output logic [PIX_W-1:0]         out_pix,
  output logic                     out_vld,
  output logic                     out_in_line,
  output logic                     out_in_frame,
  output logic [SW-1:0]            sel_active,
  output logic                     switch_pending,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               debug_pins
);

  localparam int C     = PIX_W / 3;
  localparam int XW    = (HACTIVE > 1) ? $clog2(HACTIVE) : 1;
  localparam int YW    = (VACTIVE > 1) ? $clog2(VACTIVE) : 1;
  localparam int BMAX  = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW    = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int BAR_W = (HACTIVE >= 8) ? HACTIVE / 8 : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(HACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(VACTIVE - 1);
  localparam logic [BW-1:0] VB_LAST = BW'(VBLANK - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(HBLANK - 1);
  localparam logic [SW-1:0] PAT_IDX = SW'(NUM_SRC);

  // PG_VBLANK must stay 2'b00 so debug_pins reads zero in reset.
  typedef enum logic [1:0] {
    PG_VBLANK = 2'b00,
    PG_LINE   = 2'b01,
    PG_HBLANK = 2'b10
  } pg_state_t;

  pg_state_t       pg_state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [BW-1:0]   blk;
  logic [1:0]      mode_q;

  logic            pg_vld;
  logic            pg_in_line;
  logic            pg_in_frame;
  logic [2:0]      pg_bar;
  logic            pg_chk;
  logic [PIX_W-1:0] pg_pix;

  logic [SW-1:0]    sel_tgt;
  logic [PIX_W-1:0] sel_pix;
  logic             sel_vld;
  logic             sel_line;
  logic             sel_frame;
  logic             cur_frame;
  logic             tgt_frame;
  logic             commit;

  // ---------------------------------------------------------------------
  // Pattern generator timing
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pg_state <= PG_VBLANK;
      blk      <= '0;
      x        <= '0;
      y        <= '0;
      mode_q   <= '0;
    end else begin
      case (pg_state)
        PG_VBLANK: begin
          if (blk == VB_LAST) begin
            pg_state <= PG_LINE;
            blk      <= '0;
            x        <= '0;
            y        <= '0;
            mode_q   <= pat_mode;   // mode is frozen for the whole frame
          end else begin
            blk <= blk + 1'b1;
          end
        end
        PG_LINE: begin
          if (x == X_LAST) begin
            x        <= '0;
            blk      <= '0;
            pg_state <= (y == Y_LAST) ? PG_VBLANK : PG_HBLANK;
          end else begin
            x <= x + 1'b1;
          end
        end
        PG_HBLANK: begin
          if (blk == HB_LAST) begin
            pg_state <= PG_LINE;
            blk      <= '0;
            y        <= y + 1'b1;
          end else begin
            blk <= blk + 1'b1;
          end
        end
        default: pg_state <= PG_VBLANK;
      endcase
    end
  end

  assign pg_vld      = (pg_state == PG_LINE);
  assign pg_in_line  = (pg_state == PG_LINE);
  assign pg_in_frame = (pg_state != PG_VBLANK);

  // ---------------------------------------------------------------------
  // Pattern content
  // ---------------------------------------------------------------------
  always_comb begin
    pg_bar = (32'(x) / 32'(BAR_W) > 32'd7) ? 3'd7 : 3'(32'(x) / 32'(BAR_W));
    pg_chk = (((32'(x) >> 5) ^ (32'(y) >> 5)) & 32'd1) != 32'd0;
    case (mode_q)
      // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to
      // R = ~bar[1], G = ~bar[2], B = ~bar[0].
      2'd0:    pg_pix = {{C{~pg_bar[1]}}, {C{~pg_bar[2]}}, {C{~pg_bar[0]}}};
      2'd1:    pg_pix = {3{C'(x)}};
      2'd2:    pg_pix = pg_chk ? '1 : '0;
      default: pg_pix = {C'(frame_cnt), {(2*C){1'b0}}};
    endcase
  end

  // ---------------------------------------------------------------------
  // Source selection and commit qualification
  // ---------------------------------------------------------------------
  always_comb begin
    sel_tgt = (sel_req > PAT_IDX) ? PAT_IDX : sel_req;

    sel_pix   = pg_pix;
    sel_vld   = pg_vld;
    sel_line  = pg_in_line;
    sel_frame = pg_in_frame;
    cur_frame = pg_in_frame;
    tgt_frame = pg_in_frame;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel_active == SW'(i)) begin
        sel_pix   = src_pix[i*PIX_W +: PIX_W];
        sel_vld   = src_vld[i];
        sel_line  = src_in_line[i];
        sel_frame = src_in_frame[i];
        cur_frame = src_in_frame[i];
      end
      if (sel_tgt == SW'(i)) begin
        tgt_frame = src_in_frame[i];
      end
    end

    commit = (sel_tgt != sel_active) && !cur_frame && !tgt_frame;
  end

  // ---------------------------------------------------------------------
  // Committed select, output register, frame counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_active     <= '0;
      switch_pending <= 1'b0;
      out_pix        <= '0;
      out_vld        <= 1'b0;
      out_in_line    <= 1'b0;
      out_in_frame   <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      if (commit) begin
        sel_active <= sel_tgt;
      end
      // A request that commits this cycle never shows as pending.
      switch_pending <= (sel_tgt != sel_active) && !commit;

      out_vld      <= sel_vld;
      out_in_line  <= sel_line;
      out_in_frame <= sel_frame;
      if (sel_vld) begin
        out_pix <= sel_pix;
      end

      // Counted on the same edge that drops out_in_frame.
      if (out_in_frame && !sel_frame) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign debug_pins = {pg_state, switch_pending, out_in_frame, out_in_line,
                       out_vld, 2'(sel_active)};

endmodule
